// File: rtl/bcd_seq_converter_if.sv
// Start/done handshake bundle between a requester and bcd_seq_converter.
// The BIN_W and DIGITS values must match those of the converter attached to the bundle.
interface bcd_seq_converter_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  ovf;

  modport master (output start, bin_in, input busy, done, bcd_out, ovf);
  modport slave  (input start, bin_in, output busy, done, bcd_out, ovf);
endinterface

// File: rtl/bcd_seq_converter.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Optional macro BCD_BLANK_EN: leading zero digits above the units digit are output as 4'hF.
module bcd_seq_converter #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic               clk,
  input  logic               rst,
  bcd_seq_converter_if.slave bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int CAT_W = BCD_W + BIN_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t             state_r;
  logic [BIN_W-1:0]   bin_r;
  logic [BCD_W-1:0]   acc_r;
  logic               flag_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;
  logic               done_r;
  logic [BCD_W-1:0]   bcd_out_r;
  logic               ovf_r;

  logic [CAT_W-1:0]   cat_s;
  logic [BCD_W-1:0]   acc_next_s;
  logic [BIN_W-1:0]   bin_next_s;
  logic               carry_s;

  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] acc);
    logic [BCD_W-1:0] res;
    res = acc;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc[4*k +: 4] >= 4'd5) res[4*k +: 4] = acc[4*k +: 4] + 4'd3;
      else                       res[4*k +: 4] = acc[4*k +: 4];
    end
    return res;
  endfunction

  function automatic logic [BCD_W-1:0] format_out(input logic [BCD_W-1:0] acc);
    logic [BCD_W-1:0] res;
    res = acc;
`ifdef BCD_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      // Scan down from the top digit; digit 0 is never blanked.
      for (int k = DIGITS - 1; k >= 1; k--) begin
        if (lead && (acc[4*k +: 4] == 4'd0)) res[4*k +: 4] = 4'hF;
        else                                 lead = 1'b0;
      end
    end
`endif
    return res;
  endfunction

  // One double-dabble step: correct digits, then shift {acc, bin} left by one.
  always_comb begin
    cat_s      = {add3_digits(acc_r), bin_r, 1'b0};
    carry_s    = cat_s[CAT_W-1];
    acc_next_s = cat_s[CAT_W-2 -: BCD_W];
    bin_next_s = cat_s[BIN_W-1:0];
  end

  // Conversion sequencer with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      bin_r     <= '0;
      acc_r     <= '0;
      flag_r    <= 1'b0;
      cnt_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      bcd_out_r <= '0;
      ovf_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (bus.start) begin
            bin_r   <= bus.bin_in;
            acc_r   <= '0;
            flag_r  <= 1'b0;
            cnt_r   <= CNT_W'(BIN_W);
            state_r <= SHIFT;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        SHIFT: begin
          acc_r  <= acc_next_s;
          bin_r  <= bin_next_s;
          flag_r <= flag_r | carry_s;
          cnt_r  <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            bcd_out_r <= format_out(acc_next_s);
            ovf_r     <= flag_r | carry_s;
            state_r   <= DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
          end else begin
            state_r   <= SHIFT;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.bcd_out = bcd_out_r;
  assign bus.ovf     = ovf_r;
endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench for bcd_seq_converter: three parameterisations, vector table,
// handshake corner sequences and randomized values against an arithmetic reference.
module tb_bcd_seq_converter;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bcd_seq_converter_if #(.BIN_W(8),  .DIGITS(3)) a_if ();
  bcd_seq_converter_if #(.BIN_W(8),  .DIGITS(2)) b_if ();
  bcd_seq_converter_if #(.BIN_W(16), .DIGITS(5)) c_if ();

  bcd_seq_converter #(.BIN_W(8),  .DIGITS(3)) u_a (.clk(clk), .rst(rst), .bus(a_if));
  bcd_seq_converter #(.BIN_W(8),  .DIGITS(2)) u_b (.clk(clk), .rst(rst), .bus(b_if));
  bcd_seq_converter #(.BIN_W(16), .DIGITS(5)) u_c (.clk(clk), .rst(rst), .bus(c_if));

  typedef struct {
    int          sel;
    logic [15:0] bin;
    logic [19:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  function automatic int width_of(input int sel);
    return (sel == 2) ? 16 : 8;
  endfunction

  function automatic int digits_of(input int sel);
    case (sel)
      0:       return 3;
      1:       return 2;
      default: return 5;
    endcase
  endfunction

  // Reference: decimal digits of v mod 10^digits by plain division.
  function automatic logic [63:0] ref_bcd(input longint unsigned v, input int digits);
    longint unsigned p, r;
    logic [63:0] res;
    p = 1;
    for (int k = 0; k < digits; k++) p = p * 10;
    r   = v % p;
    res = '0;
    for (int k = 0; k < digits; k++) begin
      res[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
`ifdef BCD_BLANK_EN
    r = v % p;
    p = 10;
    for (int k = 1; k < digits; k++) begin
      if (r < p) res[4*k +: 4] = 4'hF;
      p = p * 10;
    end
`endif
    return res;
  endfunction

  function automatic logic ref_ovf(input longint unsigned v, input int digits);
    longint unsigned p;
    p = 1;
    for (int k = 0; k < digits; k++) p = p * 10;
    return (v >= p);
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return a_if.done;
      1:       return b_if.done;
      default: return c_if.done;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return a_if.busy;
      1:       return b_if.busy;
      default: return c_if.busy;
    endcase
  endfunction

  function automatic logic [63:0] get_bcd(input int sel);
    case (sel)
      0:       return 64'(a_if.bcd_out);
      1:       return 64'(b_if.bcd_out);
      default: return 64'(c_if.bcd_out);
    endcase
  endfunction

  function automatic logic get_ovf(input int sel);
    case (sel)
      0:       return a_if.ovf;
      1:       return b_if.ovf;
      default: return c_if.ovf;
    endcase
  endfunction

  task automatic drive(input int sel, input logic [15:0] v, input logic s);
    case (sel)
      0:       begin a_if.start = s; a_if.bin_in = v[7:0]; end
      1:       begin b_if.start = s; b_if.bin_in = v[7:0]; end
      default: begin c_if.start = s; c_if.bin_in = v;      end
    endcase
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Accept one value, then count edges until done (bounded).
  task automatic run_conv(input int sel, input logic [15:0] v, output int lat,
                          output int busy_cnt, output logic busy_at_done);
    @(negedge clk);
    drive(sel, v, 1'b1);
    @(posedge clk); #1;
    drive(sel, v, 1'b0);
    lat      = 0;
    busy_cnt = 0;
    while (!get_done(sel) && lat < 64) begin
      if (get_busy(sel)) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    busy_at_done = get_busy(sel);
  endtask

  initial begin
    vec_t        tbl [12];
    int          lat, bcnt, n, n_done, sel;
    logic        bad;
    logic [15:0] v;

`ifdef BCD_BLANK_EN
    tbl[0]  = '{0, 16'd15,    20'h00F15, 1'b0};
    tbl[1]  = '{0, 16'd4,     20'h00FF4, 1'b0};
    tbl[2]  = '{0, 16'd12,    20'h00F12, 1'b0};
    tbl[3]  = '{0, 16'd255,   20'h00255, 1'b0};
    tbl[4]  = '{0, 16'd0,     20'h00FF0, 1'b0};
    tbl[5]  = '{0, 16'd100,   20'h00100, 1'b0};
    tbl[6]  = '{1, 16'd123,   20'h00023, 1'b1};
    tbl[7]  = '{1, 16'd42,    20'h00042, 1'b0};
    tbl[8]  = '{1, 16'd100,   20'h000F0, 1'b1};
    tbl[9]  = '{1, 16'd99,    20'h00099, 1'b0};
    tbl[10] = '{2, 16'd65535, 20'h65535, 1'b0};
    tbl[11] = '{2, 16'd10,    20'hFFF10, 1'b0};
`else
    tbl[0]  = '{0, 16'd15,    20'h00015, 1'b0};
    tbl[1]  = '{0, 16'd4,     20'h00004, 1'b0};
    tbl[2]  = '{0, 16'd12,    20'h00012, 1'b0};
    tbl[3]  = '{0, 16'd255,   20'h00255, 1'b0};
    tbl[4]  = '{0, 16'd0,     20'h00000, 1'b0};
    tbl[5]  = '{0, 16'd100,   20'h00100, 1'b0};
    tbl[6]  = '{1, 16'd123,   20'h00023, 1'b1};
    tbl[7]  = '{1, 16'd42,    20'h00042, 1'b0};
    tbl[8]  = '{1, 16'd100,   20'h00000, 1'b1};
    tbl[9]  = '{1, 16'd99,    20'h00099, 1'b0};
    tbl[10] = '{2, 16'd65535, 20'h65535, 1'b0};
    tbl[11] = '{2, 16'd10,    20'h00010, 1'b0};
`endif

    for (int s = 0; s < 3; s++) drive(s, 16'd0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(a_if.busy), 64'd0);
    chk("reset_done", 64'(a_if.done), 64'd0);
    chk("reset_bcd",  get_bcd(0),     64'd0);
    chk("reset_ovf",  64'(a_if.ovf),  64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_conv(tbl[i].sel, tbl[i].bin, lat, bcnt, bad);
      chk($sformatf("vec%0d_bcd", i),      get_bcd(tbl[i].sel),      64'(tbl[i].exp_bcd));
      chk($sformatf("vec%0d_ovf", i),      64'(get_ovf(tbl[i].sel)), 64'(tbl[i].exp_ovf));
      chk($sformatf("vec%0d_latency", i),  64'(lat),                 64'(width_of(tbl[i].sel)));
      chk($sformatf("vec%0d_busy_cyc", i), 64'(bcnt),                64'(width_of(tbl[i].sel)));
      chk($sformatf("vec%0d_busy_done", i), 64'(bad),                64'd0);
    end

    // Back-to-back: start held high, operand switched during the DONE cycle.
    @(negedge clk);
    drive(0, 16'd59, 1'b1);
    @(posedge clk); #1;
    n = 0;
    while (!a_if.done && n < 64) begin @(posedge clk); #1; n++; end
    chk("b2b_first_latency", 64'(n),   64'd8);
    chk("b2b_first_bcd",     get_bcd(0), ref_bcd(59, 3));
    drive(0, 16'd23, 1'b1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!a_if.done && n < 64);
    chk("b2b_gap",       64'(n),     64'd9);
    chk("b2b_second_bcd", get_bcd(0), ref_bcd(23, 3));
    drive(0, 16'd23, 1'b0);

    // Start pulsed mid-conversion must be ignored.
    @(negedge clk);
    drive(0, 16'd42, 1'b1);
    @(posedge clk); #1;
    drive(0, 16'd42, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    drive(0, 16'd99, 1'b1);
    @(posedge clk); #1;
    drive(0, 16'd99, 1'b0);
    n = 4;
    while (!a_if.done && n < 64) begin @(posedge clk); #1; n++; end
    chk("midshift_latency", 64'(n),     64'd8);
    chk("midshift_bcd",     get_bcd(0), ref_bcd(42, 3));
    n_done = 0;
    repeat (12) begin @(posedge clk); #1; if (a_if.done) n_done++; end
    chk("midshift_no_extra_done", 64'(n_done), 64'd0);

    // Reset during conversion clears results in every instance.
    run_conv(1, 16'd123, lat, bcnt, bad);
    chk("pre_reset_b_ovf", 64'(b_if.ovf), 64'd1);
    @(negedge clk);
    drive(0, 16'd200, 1'b1);
    @(posedge clk); #1;
    drive(0, 16'd200, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy",  64'(a_if.busy), 64'd0);
    chk("midrst_done",  64'(a_if.done), 64'd0);
    chk("midrst_bcd",   get_bcd(0),     64'd0);
    chk("midrst_b_bcd", get_bcd(1),     64'd0);
    chk("midrst_b_ovf", 64'(b_if.ovf),  64'd0);
    n_done = 0;
    repeat (12) begin @(posedge clk); #1; if (a_if.done) n_done++; end
    chk("midrst_no_done", 64'(n_done), 64'd0);
    run_conv(0, 16'd7, lat, bcnt, bad);
    chk("postrst_bcd",     get_bcd(0), ref_bcd(7, 3));
    chk("postrst_latency", 64'(lat),   64'd8);

    // Randomized operands on all three widths against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 2));
      v   = (sel == 2) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 255));
      run_conv(sel, v, lat, bcnt, bad);
      chk($sformatf("rnd%0d_s%0d_v%0d_bcd", i, sel, v), get_bcd(sel),
          ref_bcd(longint'(v), digits_of(sel)));
      chk($sformatf("rnd%0d_s%0d_v%0d_ovf", i, sel, v), 64'(get_ovf(sel)),
          64'(ref_ovf(longint'(v), digits_of(sel))));
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(width_of(sel)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- Replaces the fixed 8-bit, two-digit combinational BCD block in the clock datapath.
- Converts any BIN_W-bit value into DIGITS packed BCD digits over BIN_W cycles.
- Uses a start/done handshake, so one small converter can be time-shared across hours/minutes/seconds fields.

Parameters:
BIN_W, 8, width of binary input (1..32)
DIGITS, 3, number of BCD digits produced (1..10)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  request conversion of bin_in; sampled only when accepted (see Behaviour)
bin_in  in  BIN_W  unsigned binary operand, captured on accepting edge
busy  out  1  high while conversion in progress (SHIFT state)
done  out  1  single-cycle pulse: bcd_out/ovf valid and updated
bcd_out  out  4*DIGITS  packed BCD, digit 0 (units) in [3:0], digit k in [4k+3:4k]
ovf  out  1  result did not fit in DIGITS digits

Behaviour:
- Reset: one clock, synchronous, active-high, no asynchronous path. Outputs and state after reset:
  - state=IDLE
  - busy=0, done=0, ovf=0
  - bcd_out=0 (all zero digits, also with the optional feature enabled)
  - counter and shift register cleared
- Reset mid-conversion aborts on the next edge. No done pulse. bcd_out is cleared.
- States: IDLE, SHIFT, DONE.
- Accept rule: start=1 on an edge while in IDLE or DONE:
  - captures bin_in into the binary shift register;
  - clears the BCD accumulator;
  - clears internal overflow flag;
  - loads counter=BIN_W;
  - moves to SHIFT.
- start while in SHIFT is ignored (not queued). bin_in changes during SHIFT have no effect.
- SHIFT, each cycle:
  - every 4-bit digit of the accumulator >=5 gets +3;
  - then the {accumulator, binary} register shifts left 1;
  - the bit leaving the top digit ORs into the internal overflow flag;
  - counter decrements.
- When counter reaches 1, the next edge:
  - registers the accumulator into bcd_out and the flag into ovf;
  - moves to DONE.
- Latency: accept edge E0. SHIFT occupies cycles after E0..E_BIN_W. At edge E_BIN_W, done=1 and outputs update. done is high for exactly the one cycle following E_BIN_W (BIN_W cycles after accept).
- busy=1 exactly in SHIFT. done=1 exactly in DONE. busy and done are never both 1.
- DONE -> IDLE next edge if start=0. DONE -> SHIFT if start=1 (back-to-back, no idle gap).
- bcd_out and ovf hold their value from the last DONE until the next DONE or reset.
- Overflow: if bin_in >= 10^DIGITS, then ovf=1 and bcd_out = bin_in mod 10^DIGITS, digits correct.
- bin_in=0 gives all-zero digits, ovf=0.
- No digit of bcd_out is ever >9 (except blank code under the optional feature).

Optional Feature:
Macro BCD_BLANK_EN.
- Defined: when bcd_out is registered in DONE, leading zero digits above digit 0 are replaced by 4'hF (blank code for the seven-segment decoder). Digit 0 is never blanked, so value 0 shows as ...FFF0. Blanking applies only to the registered output. Reset value stays all zeros. ovf is unaffected.
- Not defined: leading zeros appear as 4'h0. No blanking logic is synthesised.

Test Plan:
- Default params, rst 2 cycles, start with bin_in=15 -> busy high 8 cycles, done pulse 8 cycles after accept, bcd_out=12'h015, ovf=0.
- bin_in=4, then 12, then 255, each waiting for done -> bcd_out 12'h004, 12'h012, 12'h255, ovf=0. With BCD_BLANK_EN: 12'hFF4, 12'hF12, 12'h255; bin_in=0 -> 12'hFF0.
- Back-to-back: start held high, bin_in=59 then 23 switched in the DONE cycle -> done pulses exactly 9 cycles apart, results 12'h059 then 12'h023. start pulsed mid-SHIFT with bin_in=99 -> ignored, result unchanged.
- Overflow: BIN_W=8, DIGITS=2, bin_in=123 -> bcd_out=8'h23, ovf=1. Next conversion 42 -> 8'h42, ovf=0.
- Reset mid-operation: rst asserted 3 cycles after accepting 200 -> next cycle busy=0, done=0, bcd_out=0. No done pulse follows. A new start with 7 -> 12'h007.
- Wide params BIN_W=16, DIGITS=5, bin_in=65535 -> done after 16 cycles, bcd_out=20'h65535, ovf=0.
